// File: rtl/axis_traffic_sink_if.sv
// axis_traffic_sink_if: AXI-Stream data/handshake bundle between a stream source and the traffic sink.
interface axis_traffic_sink_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_traffic_sink.sv
// axis_traffic_sink: accepts a run of EXPECT_BEATS beats and checks them against SEED + n.
// Optional feature macro SINK_BACKPRESSURE_EN: tready drops one cycle in every READY_PERIOD.
module axis_traffic_sink #(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    EXPECT_BEATS = 16,
    parameter logic [DATA_WIDTH-1:0] SEED         = '0,
    parameter int                    READY_PERIOD = 4,
    parameter int                    TIMEOUT      = 1024
) (
    input  logic               clk,
    input  logic               reset,
    axis_traffic_sink_if.slave axis,
    input  logic               start,
    output logic               done,
    output logic               pass,
    output logic               timed_out,
    output logic [15:0]        beat_count,
    output logic [15:0]        error_count,
    output logic [15:0]        first_err_idx
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX   = 16'(EXPECT_BEATS - 1);
    localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT);
    localparam logic [15:0] NO_ERR     = 16'hFFFF;

    state_t                state_r;
    state_t                state_next_s;
    logic                  tready_r;
    logic                  done_r;
    logic                  pass_r;
    logic                  timed_out_r;
    logic [15:0]           beat_count_r;
    logic [15:0]           error_count_r;
    logic [15:0]           first_err_r;
    logic [DATA_WIDTH-1:0] expect_r;
    logic [31:0]           idle_r;

    logic                  start_run_s;
    logic                  accept_s;
    logic                  mismatch_s;
    logic                  last_s;
    logic                  timeout_s;
    logic                  ready_next_s;
    logic [15:0]           err_next_s;
    logic [15:0]           first_next_s;

    // Handshake decode and per-beat comparison for the current cycle
    always_comb begin
        start_run_s  = start && (state_r != RUN);
        accept_s     = (state_r == RUN) && axis.tvalid && tready_r;
        mismatch_s   = accept_s && (axis.tdata != expect_r);
        last_s       = accept_s && (beat_count_r == LAST_IDX);
        // Timeout is taken from the registered idle count, so a beat landing on that edge is still counted
        timeout_s    = (state_r == RUN) && (idle_r == IDLE_LIMIT);
        err_next_s   = error_count_r;
        first_next_s = first_err_r;
        if (mismatch_s) begin
            if (error_count_r != 16'hFFFF) begin
                err_next_s = error_count_r + 16'd1;
            end else begin
                err_next_s = error_count_r;
            end
            if (first_err_r == NO_ERR) begin
                first_next_s = beat_count_r;
            end else begin
                first_next_s = first_err_r;
            end
        end else begin
            err_next_s   = error_count_r;
            first_next_s = first_err_r;
        end
    end

    // Run-control next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = RUN;
                else       state_next_s = IDLE;
            end
            RUN: begin
                if (timeout_s || last_s) state_next_s = DONE;
                else                     state_next_s = RUN;
            end
            DONE: begin
                if (start) state_next_s = RUN;
                else       state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Run-control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifdef SINK_BACKPRESSURE_EN
    localparam int               BP_W    = $clog2(READY_PERIOD);
    localparam logic [BP_W-1:0]  BP_LAST = BP_W'(READY_PERIOD - 1);

    logic [BP_W-1:0] bp_r;
    logic [BP_W-1:0] bp_next_s;

    // Backpressure phase for the next RUN cycle; tready is low on the last phase
    always_comb begin
        if (bp_r == BP_LAST) begin
            bp_next_s = '0;
        end else begin
            bp_next_s = bp_r + BP_W'(1);
        end
        ready_next_s = (bp_next_s != BP_LAST);
    end

    // Backpressure phase counter, restarted at 0 on RUN entry
    always_ff @(posedge clk) begin
        if (reset) begin
            bp_r <= '0;
        end else if (start_run_s) begin
            bp_r <= '0;
        end else if (state_r == RUN) begin
            bp_r <= bp_next_s;
        end else begin
            bp_r <= '0;
        end
    end
`else
    // Without backpressure the sink is always ready during RUN
    always_comb begin
        ready_next_s = 1'b1;
    end
`endif

    // Run counters, checker state and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            tready_r      <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timed_out_r   <= 1'b0;
            beat_count_r  <= 16'd0;
            error_count_r <= 16'd0;
            first_err_r   <= NO_ERR;
            expect_r      <= SEED;
            idle_r        <= 32'd0;
        end else if (start_run_s) begin
            tready_r      <= 1'b1;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timed_out_r   <= 1'b0;
            beat_count_r  <= 16'd0;
            error_count_r <= 16'd0;
            first_err_r   <= NO_ERR;
            expect_r      <= SEED;
            idle_r        <= 32'd0;
        end else if (state_r == RUN) begin
            error_count_r <= err_next_s;
            first_err_r   <= first_next_s;
            if (accept_s) begin
                beat_count_r <= beat_count_r + 16'd1;
                expect_r     <= expect_r + DATA_WIDTH'(1);
                idle_r       <= 32'd0;
            end else begin
                idle_r       <= idle_r + 32'd1;
            end
            if (state_next_s == DONE) begin
                tready_r    <= 1'b0;
                done_r      <= 1'b1;
                timed_out_r <= timeout_s;
                pass_r      <= (err_next_s == 16'd0) && !timeout_s;
            end else begin
                tready_r    <= ready_next_s;
            end
        end else begin
            tready_r <= 1'b0;
        end
    end

    assign axis.tready   = tready_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign timed_out     = timed_out_r;
    assign beat_count    = beat_count_r;
    assign error_count   = error_count_r;
    assign first_err_idx = first_err_r;
endmodule

// File: tb/tb_axis_traffic_sink.sv
// tb_axis_traffic_sink: table-driven runs with a beat scoreboard, plus timeout, reset-abort and wrap-around sequences.
module tb_axis_traffic_sink;
    localparam int          DW    = 64;
    localparam int          BEATS = 16;
    localparam int          RP    = 4;
    localparam int          TMO   = 8;
    localparam logic [63:0] WSEED = 64'hFFFF_FFFF_FFFF_FFFE;
`ifdef SINK_BACKPRESSURE_EN
    localparam int FULL_RUN_CYC = BEATS + (BEATS - 1) / (RP - 1);
`else
    localparam int FULL_RUN_CYC = BEATS;
`endif

    typedef struct {
        logic [15:0] bc;
        logic [15:0] ec;
        logic [15:0] fe;
    } exp_t;

    typedef struct {
        int          bad_a;
        logic [63:0] val_a;
        int          bad_b;
        logic [63:0] val_b;
        logic        exp_pass;
        logic [15:0] exp_err;
        logic [15:0] exp_first;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start_w;
    logic        done, pass, timed_out;
    logic [15:0] beat_count, error_count, first_err_idx;
    logic        w_done, w_pass, w_timed_out;
    logic [15:0] w_beat_count, w_error_count, w_first_err_idx;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    logic [15:0] m_bc, m_ec, m_fe;
    vec_t        tbl[4];

    axis_traffic_sink_if #(.DATA_WIDTH(DW)) s_if ();
    axis_traffic_sink_if #(.DATA_WIDTH(DW)) w_if ();

    always #5 clk = ~clk;

    axis_traffic_sink #(
        .DATA_WIDTH(DW), .EXPECT_BEATS(BEATS), .SEED(64'h0), .READY_PERIOD(RP), .TIMEOUT(TMO)
    ) u_dut (
        .clk(clk), .reset(reset), .axis(s_if), .start(start),
        .done(done), .pass(pass), .timed_out(timed_out),
        .beat_count(beat_count), .error_count(error_count), .first_err_idx(first_err_idx)
    );

    axis_traffic_sink #(
        .DATA_WIDTH(DW), .EXPECT_BEATS(4), .SEED(WSEED), .READY_PERIOD(RP), .TIMEOUT(TMO)
    ) u_wrap (
        .clk(clk), .reset(reset), .axis(w_if), .start(start_w),
        .done(w_done), .pass(w_pass), .timed_out(w_timed_out),
        .beat_count(w_beat_count), .error_count(w_error_count), .first_err_idx(w_first_err_idx)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ready(input int cyc);
`ifdef SINK_BACKPRESSURE_EN
        exp_ready = ((cyc % RP) != (RP - 1));
`else
        exp_ready = 1'b1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        m_bc = 16'd0;
        m_ec = 16'd0;
        m_fe = 16'hFFFF;
        check("start_bc", 64'(beat_count), 64'd0);
        check("start_ec", 64'(error_count), 64'd0);
        check("start_fe", 64'(first_err_idx), 64'hFFFF);
        check("start_done", 64'(done), 64'd0);
        check("start_tready", 64'(s_if.tready), 64'd1);
    endtask

    // Drives n beats of 0,1,2.. (two may be corrupted), scoreboarding each acceptance
    task automatic send_stream(input int n, input int bad_a, input logic [63:0] val_a,
                               input int bad_b, input logic [63:0] val_b,
                               input int start_at, output int cyc);
        int   k;
        exp_t e;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 200) begin
            s_if.tdata  = (k == bad_a) ? val_a : (k == bad_b) ? val_b : 64'(k);
            s_if.tvalid = 1'b1;
            start       = (k == start_at);
            check("tready_pattern", 64'(s_if.tready), 64'(exp_ready(cyc)));
            if (s_if.tready) begin
                if (s_if.tdata != 64'(k)) begin
                    if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
                    if (m_fe == 16'hFFFF) m_fe = 16'(k);
                end
                m_bc = 16'(k + 1);
                sb_q.push_back('{m_bc, m_ec, m_fe});
                k++;
            end
            step();
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("beat_count", 64'(beat_count), 64'(e.bc));
                check("error_count", 64'(error_count), 64'(e.ec));
                check("first_err_idx", 64'(first_err_idx), 64'(e.fe));
            end
        end
        s_if.tvalid = 1'b0;
        start       = 1'b0;
        if (k < n) check("stream_bound", 64'(k), 64'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int w;
        int k;

        tbl[0] = '{-1, 64'h0,    -1, 64'h0,                  1'b1, 16'd0, 16'hFFFF};
        tbl[1] = '{ 5, 64'hDEAD,  9, 64'h0,                  1'b0, 16'd2, 16'd5};
        tbl[2] = '{ 0, 64'h1,    15, 64'h0,                  1'b0, 16'd2, 16'd0};
        tbl[3] = '{ 7, 64'h8000_0000_0000_0007, -1, 64'h0,   1'b0, 16'd1, 16'd7};

        reset       = 1'b1;
        start       = 1'b0;
        start_w     = 1'b0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        w_if.tdata  = '0;
        w_if.tvalid = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("rst_tready", 64'(s_if.tready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_timed_out", 64'(timed_out), 64'd0);
        check("rst_bc", 64'(beat_count), 64'd0);
        check("rst_ec", 64'(error_count), 64'd0);
        check("rst_fe", 64'(first_err_idx), 64'hFFFF);
        reset = 1'b0;
        step();
        check("idle_tready", 64'(s_if.tready), 64'd0);

        // Table: full runs with clean and corrupted data; run 0 also pulses start mid-run
        for (int i = 0; i < 4; i++) begin
            start_run();
            send_stream(BEATS, tbl[i].bad_a, tbl[i].val_a, tbl[i].bad_b, tbl[i].val_b,
                        (i == 0) ? 4 : -1, cyc);
            check("run_cycles", 64'(cyc), 64'(FULL_RUN_CYC));
            check("run_done", 64'(done), 64'd1);
            check("run_pass", 64'(pass), 64'(tbl[i].exp_pass));
            check("run_bc", 64'(beat_count), 64'(BEATS));
            check("run_ec", 64'(error_count), 64'(tbl[i].exp_err));
            check("run_fe", 64'(first_err_idx), 64'(tbl[i].exp_first));
            check("run_timed_out", 64'(timed_out), 64'd0);
            check("run_tready_off", 64'(s_if.tready), 64'd0);
            step();
            check("done_hold", 64'(done), 64'd1);
        end

        // Timeout: three beats then silence
        start_run();
        send_stream(3, -1, 64'h0, -1, 64'h0, -1, cyc);
        w = 0;
        while (!done && w < 20) begin
            step();
            w++;
        end
        check("timeout_latency_ok", 64'((w >= TMO) && (w <= TMO + 1)), 64'd1);
        check("timeout_done", 64'(done), 64'd1);
        check("timeout_flag", 64'(timed_out), 64'd1);
        check("timeout_bc", 64'(beat_count), 64'd3);
        check("timeout_pass", 64'(pass), 64'd0);

        // Reset mid-run (with start held) aborts; a fresh run then passes
        start_run();
        send_stream(8, 3, 64'hBAD, -1, 64'h0, -1, cyc);
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check("abort_bc", 64'(beat_count), 64'd0);
        check("abort_ec", 64'(error_count), 64'd0);
        check("abort_fe", 64'(first_err_idx), 64'hFFFF);
        check("abort_tready", 64'(s_if.tready), 64'd0);
        step();
        check("abort_no_done", 64'(done), 64'd0);
        check("abort_idle_tready", 64'(s_if.tready), 64'd0);
        start_run();
        send_stream(BEATS, -1, 64'h0, -1, 64'h0, -1, cyc);
        check("rerun_done", 64'(done), 64'd1);
        check("rerun_pass", 64'(pass), 64'd1);
        check("rerun_bc", 64'(beat_count), 64'(BEATS));

        // Wrap-around of the expected value past 2^64
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        k = 0;
        w = 0;
        while (k < 4 && w < 12) begin
            w_if.tdata  = WSEED + 64'(k);
            w_if.tvalid = 1'b1;
            if (w_if.tready) k++;
            step();
            w++;
        end
        w_if.tvalid = 1'b0;
        check("wrap_done", 64'(w_done), 64'd1);
        check("wrap_pass", 64'(w_pass), 64'd1);
        check("wrap_ec", 64'(w_error_count), 64'd0);
        check("wrap_bc", 64'(w_beat_count), 64'd4);
        check("wrap_fe", 64'(w_first_err_idx), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
